// File: rtl/pitch_pkg.sv
// Shared types and constants for the pitch-detect chain.
package pitch_pkg;

  localparam int DATA_W     = 16;
  localparam int CNT_W      = 12;
  localparam int AVG_DEPTH  = 4;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]         period_t;

  typedef enum logic [1:0] {
    SEEK_LOW,
    SEEK_HIGH,
    MEAS_LOW,
    MEAS_HIGH
  } zc_state_t;

endpackage

// File: rtl/period_averager.sv
// Running average of the last four accepted periods. A pulse is issued only
// once four periods have been collected since reset or the last clear.
module period_averager
  import pitch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_valid,
  input  logic [CNT_W-1:0] acc_period,
  input  logic             clear,
  output logic [CNT_W-1:0] avg_period,
  output logic             avg_valid,
  output logic             no_pitch
);

  period_t           hist_q [AVG_DEPTH];
  period_t           hist_d [AVG_DEPTH];
  logic [2:0]        fill_q, fill_d;
  period_t           avg_q, avg_d;
  logic              valid_q, valid_d;
  logic              no_pitch_q, no_pitch_d;
  logic [CNT_W+1:0]  sum;

  // Shift a new period into the history, or wipe it when tracking is lost.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    avg_d      = avg_q;
    valid_d    = 1'b0;
    no_pitch_d = no_pitch_q;
    sum        = '0;
    if (clear) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = '0;
      fill_d     = '0;
      no_pitch_d = 1'b1;
    end else if (acc_valid) begin
      hist_d[0] = acc_period;
      for (int i = 1; i < AVG_DEPTH; i++) hist_d[i] = hist_q[i-1];
      fill_d = (fill_q == 3'(AVG_DEPTH)) ? fill_q : fill_q + 3'd1;
      sum = {2'b00, hist_d[0]} + {2'b00, hist_d[1]}
          + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
      if (fill_d == 3'(AVG_DEPTH)) begin
        avg_d      = sum[CNT_W+1:2];
        valid_d    = 1'b1;
        no_pitch_d = 1'b0;
      end
    end
  end

  // History, fill level and averaged outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
      fill_q     <= '0;
      avg_q      <= '0;
      valid_q    <= 1'b0;
      no_pitch_q <= 1'b1;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      avg_q      <= avg_d;
      valid_q    <= valid_d;
      no_pitch_q <= no_pitch_d;
    end
  end

  assign avg_period = avg_q;
  assign avg_valid  = valid_q;
  assign no_pitch   = no_pitch_q;

endmodule

// File: rtl/zero_cross_period.sv
// Pitch-period estimator: counts decimated samples between rising zero
// crossings (with hysteresis) and publishes the period or a no-pitch flag.
// Optional build macro PERIOD_AVG_EN: publish the average of the last four
// accepted periods instead of the raw period (one extra cycle of latency).
module zero_cross_period
  import pitch_pkg::*;
#(
  parameter int HYST       = 256,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 2047
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] signal_in,
  input  logic                     valid_in,
  output logic [CNT_W-1:0]         period_out,
  output logic                     period_valid,
  output logic                     no_pitch
);

  localparam sample_t          POS_TH = sample_t'(HYST);
  localparam sample_t          NEG_TH = sample_t'(-HYST);
  localparam logic [CNT_W:0]   MIN_C  = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_C  = (CNT_W+1)'(MAX_PERIOD);

  zc_state_t       state_q, state_d;
  period_t         counter_q, counter_d;
  period_t         raw_period_q, raw_period_d;
  logic            raw_valid_q, raw_valid_d;
  logic            accept, timeout;
  logic            is_low, is_high;
  logic [CNT_W:0]  count_inc;
  sample_t         sample;

  assign sample    = signal_in;
  assign is_low    = (sample < NEG_TH);
  assign is_high   = (sample >= POS_TH);
  assign count_inc = {1'b0, counter_q} + 1'b1;

  // Crossing detector and sample counter; moves only on qualified samples.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    accept       = 1'b0;
    timeout      = 1'b0;
    if (valid_in) begin
      case (state_q)
        SEEK_LOW: begin
          if (is_low) state_d = SEEK_HIGH;
        end
        SEEK_HIGH: begin
          if (is_high) begin
            counter_d = '0;
            state_d   = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (count_inc > MAX_C) begin
            timeout = 1'b1;
          end else begin
            counter_d = count_inc[CNT_W-1:0];
            if (is_low) state_d = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (is_high) begin
            accept    = (count_inc >= MIN_C) && (count_inc <= MAX_C);
            counter_d = '0;
            state_d   = MEAS_LOW;
          end else if (count_inc > MAX_C) begin
            timeout = 1'b1;
          end else begin
            counter_d = count_inc[CNT_W-1:0];
          end
        end
        default: state_d = SEEK_LOW;
      endcase
    end
    if (timeout) begin
      counter_d = '0;
      state_d   = SEEK_LOW;
    end
    raw_valid_d  = accept;
    raw_period_d = accept ? count_inc[CNT_W-1:0] : raw_period_q;
  end

  // Detector state, counter and last accepted raw period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEEK_LOW;
      counter_q    <= '0;
      raw_period_q <= '0;
      raw_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      raw_period_q <= raw_period_d;
      raw_valid_q  <= raw_valid_d;
    end
  end

`ifdef PERIOD_AVG_EN

  logic timeout_q;

  // Delay the timeout so it lines up with the registered accept pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout;
  end

  period_averager u_avg (
    .clk        (clk),
    .reset      (reset),
    .acc_valid  (raw_valid_q),
    .acc_period (raw_period_q),
    .clear      (timeout_q),
    .avg_period (period_out),
    .avg_valid  (period_valid),
    .no_pitch   (no_pitch)
  );

`else

  logic no_pitch_q, no_pitch_d;

  // Pitch is tracked from the first accepted period until a timeout.
  always_comb begin
    no_pitch_d = no_pitch_q;
    if (timeout)     no_pitch_d = 1'b1;
    else if (accept) no_pitch_d = 1'b0;
  end

  // No-pitch flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) no_pitch_q <= 1'b1;
    else       no_pitch_q <= no_pitch_d;
  end

  assign period_out   = raw_period_q;
  assign period_valid = raw_valid_q;
  assign no_pitch     = no_pitch_q;

`endif

endmodule

// File: tb/tb_zero_cross_period.sv
// Self-checking bench for zero_cross_period: directed waveforms plus
// randomized square/noise stimulus against a sample-level reference model.
module tb_zero_cross_period;
  import pitch_pkg::*;

  localparam int HYST  = 256;
  localparam int MIN_P = 8;
  localparam int MAX_P = 2047;

`ifdef PERIOD_AVG_EN
  localparam int T1_PULSES = 1;
  localparam int T5_PULSES = 0;
  localparam int T5_NOPITCH = 1;
  localparam int T6_PULSES = 0;
  localparam int T7_PULSES = 0;
  localparam int T8_PULSES = 0;
  localparam int T9_PULSES = 0;
  localparam int T10_PULSES = 1;
  localparam int T10_PERIOD = 42;
`else
  localparam int T1_PULSES = 4;
  localparam int T5_PULSES = 2;
  localparam int T5_NOPITCH = 0;
  localparam int T6_PULSES = 2;
  localparam int T7_PULSES = 2;
  localparam int T8_PULSES = 3;
  localparam int T9_PULSES = 1;
  localparam int T10_PULSES = 4;
  localparam int T10_PERIOD = 44;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] signal_in = '0;
  logic                     valid_in = 1'b0;
  logic [CNT_W-1:0]         period_out;
  logic                     period_valid;
  logic                     no_pitch;

  int n_cmp = 0;
  int n_fail = 0;
  int dut_pulses = 0;
  int model_pulses = 0;

  always #5 clk = ~clk;

  zero_cross_period #(
    .HYST       (HYST),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .signal_in    (signal_in),
    .valid_in     (valid_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .no_pitch     (no_pitch)
  );

  // Reference model: "have a reference crossing", "seen a low since then",
  // and the number of samples since the reference.
  bit m_ref = 0;
  bit m_low = 0;
  int m_n = 0;
  int exp_period = 0;
  bit exp_valid = 0;
  bit exp_np = 1;
  bit m_acc, m_tmo;
  int m_per;
`ifdef PERIOD_AVG_EN
  int hist[$];
  bit pend_acc = 0;
  bit pend_tmo = 0;
  int pend_per = 0;
`endif

  function automatic void model_step(input int s, output bit acc, output bit tmo, output int per);
    acc = 0; tmo = 0; per = 0;
    if (!m_ref) begin
      if (!m_low) begin
        if (s < -HYST) m_low = 1;
      end else if (s >= HYST) begin
        m_ref = 1; m_low = 0; m_n = 0;
      end
    end else begin
      m_n++;
      if (m_low && s >= HYST) begin
        per = m_n;
        acc = (per >= MIN_P) && (per <= MAX_P);
        m_n = 0; m_low = 0;
      end else if (m_n > MAX_P) begin
        tmo = 1; m_ref = 0; m_low = 0; m_n = 0;
      end else if (s < -HYST) begin
        m_low = 1;
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ref = 0; m_low = 0; m_n = 0;
      exp_period = 0; exp_valid = 0; exp_np = 1;
`ifdef PERIOD_AVG_EN
      hist.delete(); pend_acc = 0; pend_tmo = 0; pend_per = 0;
`endif
    end else begin
      exp_valid = 0;
`ifdef PERIOD_AVG_EN
      if (pend_tmo) begin
        hist.delete();
        exp_np = 1;
      end else if (pend_acc) begin
        hist.push_front(pend_per);
        if (hist.size() > 4) void'(hist.pop_back());
        if (hist.size() == 4) begin
          exp_period = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
          exp_valid = 1; exp_np = 0; model_pulses++;
        end
      end
      pend_acc = 0; pend_tmo = 0;
`endif
      m_acc = 0; m_tmo = 0; m_per = 0;
      if (valid_in) model_step(int'(signal_in), m_acc, m_tmo, m_per);
`ifdef PERIOD_AVG_EN
      pend_acc = m_acc; pend_tmo = m_tmo; pend_per = m_per;
`else
      if (m_acc) begin
        exp_period = m_per; exp_valid = 1; exp_np = 0; model_pulses++;
      end
      if (m_tmo) exp_np = 1;
`endif
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Compare every cycle on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    checkOutput("period_out", int'(period_out), exp_period);
    checkOutput("period_valid", int'(period_valid), int'(exp_valid));
    checkOutput("no_pitch", int'(no_pitch), int'(exp_np));
    if (period_valid === 1'b1) dut_pulses++;
  end

  // Drive one sample, then a gap of idle clocks with junk on the data bus.
  task automatic applyStimulus(input int s, input int gap);
    signal_in = sample_t'(s);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int g = 0; g < gap; g++) begin
      signal_in = sample_t'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic square(input int hl, input int ll, input int hi, input int lo,
                        input int periods, input int gap);
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < hl; k++) applyStimulus(hi, gap);
      for (int k = 0; k < ll; k++) applyStimulus(lo, gap);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic doReset(input string name);
    #2 reset = 1'b1;
    #1;
    checkOutput({name, " rst period_out"}, int'(period_out), 0);
    checkOutput({name, " rst period_valid"}, int'(period_valid), 0);
    checkOutput({name, " rst no_pitch"}, int'(no_pitch), 1);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic checkPulses(input string name, input int d0, input int m0, input int lit);
    checkOutput({name, " dut pulses"}, dut_pulses - d0, lit);
    checkOutput({name, " model pulses"}, model_pulses - m0, lit);
  endtask

  initial begin
    int d0, m0, s;
    sample_t r;
    @(posedge clk); #1;
    doReset("init");

    // Square +-4000, 20/20, one sample every 4 clocks.
    d0 = dut_pulses; m0 = model_pulses;
    square(20, 20, 4000, -4000, 6, 3);
    idle(4);
    checkPulses("t1", d0, m0, T1_PULSES);
    checkOutput("t1 period_out", int'(period_out), 40);
    checkOutput("t1 model period", exp_period, 40);
    checkOutput("t1 no_pitch", int'(no_pitch), 0);

    // Flat input after lock: timeout, period held.
    d0 = dut_pulses; m0 = model_pulses;
    for (int i = 0; i < 2100; i++) applyStimulus(0, 0);
    idle(4);
    checkPulses("t2", d0, m0, 0);
    checkOutput("t2 period_out", int'(period_out), 40);
    checkOutput("t2 no_pitch", int'(no_pitch), 1);

    // Low-amplitude wave inside the hysteresis band.
    d0 = dut_pulses; m0 = model_pulses;
    for (int i = 0; i < 2100; i++) applyStimulus(150 - (i % 61) * 5, 0);
    idle(4);
    checkPulses("t3", d0, m0, 0);
    checkOutput("t3 no_pitch", int'(no_pitch), 1);

    // Period 40 with noise bursts around zero.
    d0 = dut_pulses; m0 = model_pulses;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 40; k++) begin
        if (k < 18)      s = 4000;
        else if (k < 20) s = int'($urandom_range(0, 400)) - 200;
        else if (k < 38) s = -4000;
        else             s = int'($urandom_range(0, 400)) - 200;
        applyStimulus(s, 0);
      end
    end
    idle(4);
    checkPulses("t4", d0, m0, T1_PULSES);
    checkOutput("t4 period_out", int'(period_out), 40);

    // Too-short period, then period 50.
    doReset("t5");
    d0 = dut_pulses; m0 = model_pulses;
    square(3, 3, 4000, -4000, 20, 0);
    idle(4);
    checkPulses("t5a", d0, m0, 0);
    checkOutput("t5a no_pitch", int'(no_pitch), 1);
    d0 = dut_pulses; m0 = model_pulses;
    square(25, 25, 4000, -4000, 3, 0);
    idle(4);
    checkPulses("t5b", d0, m0, T5_PULSES);
    checkOutput("t5b no_pitch", int'(no_pitch), T5_NOPITCH);
`ifndef PERIOD_AVG_EN
    checkOutput("t5b period_out", int'(period_out), 50);
`endif

    // Reset while measuring, then a fresh lock.
    for (int i = 0; i < 5; i++) applyStimulus(-4000, 0);
    doReset("t6");
    d0 = dut_pulses; m0 = model_pulses;
    square(20, 20, 4000, -4000, 4, 0);
    idle(4);
    checkPulses("t6", d0, m0, T6_PULSES);

    // Hysteresis edges: -256 is not low, -257 is; +256 is high.
    doReset("t7");
    d0 = dut_pulses; m0 = model_pulses;
    square(20, 20, 256, -256, 5, 0);
    idle(4);
    checkPulses("t7a", d0, m0, 0);
    d0 = dut_pulses; m0 = model_pulses;
    square(20, 20, 256, -257, 4, 0);
    idle(4);
    checkPulses("t7b", d0, m0, T7_PULSES);

    // Period 7 rejected, period 8 accepted.
    doReset("t8");
    d0 = dut_pulses; m0 = model_pulses;
    square(4, 3, 4000, -4000, 6, 0);
    square(4, 4, 4000, -4000, 4, 0);
    idle(4);
    checkPulses("t8", d0, m0, T8_PULSES);

    // Longest accepted period.
    doReset("t9");
    d0 = dut_pulses; m0 = model_pulses;
    square(1000, 1047, 4000, -4000, 3, 0);
    idle(4);
    checkPulses("t9", d0, m0, T9_PULSES);
`ifndef PERIOD_AVG_EN
    checkOutput("t9 period_out", int'(period_out), 2047);
`endif

    // Periods 40,40,44,44 after the reference.
    doReset("t10");
    d0 = dut_pulses; m0 = model_pulses;
    square(20, 20, 4000, -4000, 3, 0);
    square(22, 22, 4000, -4000, 2, 0);
    for (int k = 0; k < 20; k++) applyStimulus(4000, 0);
    idle(4);
    checkPulses("t10", d0, m0, T10_PULSES);
    checkOutput("t10 period_out", int'(period_out), T10_PERIOD);
    checkOutput("t10 model period", exp_period, T10_PERIOD);

    // Randomized square waves with noise and gaps, checked by the model.
    doReset("t11");
    for (int seg = 0; seg < 60; seg++) begin
      int hl, ll, amp;
      hl = int'($urandom_range(2, 60));
      ll = int'($urandom_range(2, 60));
      amp = int'($urandom_range(257, 20000));
      for (int k = 0; k < hl + ll; k++) begin
        s = (k < hl) ? amp : -amp;
        if ($urandom_range(0, 7) == 0) s = int'($urandom_range(0, 510)) - 255;
        applyStimulus(s, int'($urandom_range(0, 2)));
      end
      if (seg == 30) begin
        for (int i = 0; i < 2100; i++) applyStimulus(int'($urandom_range(0, 400)) - 200, 0);
      end
    end
    for (int i = 0; i < 300; i++) begin
      r = sample_t'($urandom);
      applyStimulus(int'(r), int'($urandom_range(0, 1)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
